// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus a bit-serial shift-add
// multiplier and restoring divider that share one product/remainder register pair.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_operation,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_NOR   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_LUI   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_MULHU = 4'd9;
    localparam logic [3:0] OP_DIVU  = 4'd10;
    localparam logic [3:0] OP_REMU  = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_md;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_divzero;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_single_res;
    logic             w_single_ovf;
    logic             w_single_dz;
    logic             w_multi;
    logic             w_start_mul;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;
    logic [WIDTH-1:0] w_run_res;

    assign busy     = r_busy;
    assign done     = r_done;
    assign Result   = r_result;
    assign Zero     = r_zero;
    assign Overflow = r_overflow;
    assign DivZero  = r_divzero;

    assign w_sum  = A + B;
    assign w_diff = A - B;

    // Decode of the incoming request; divide by zero is resolved here in one cycle.
    always_comb begin
        w_single_res = '0;
        w_single_ovf = 1'b0;
        w_single_dz  = 1'b0;
        w_multi      = 1'b0;
        case (ALU_operation)
            OP_ADD: begin
                w_single_res = w_sum;
                w_single_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_single_res = w_diff;
                w_single_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  w_single_res = A & B;
            OP_OR:   w_single_res = A | B;
            OP_XOR:  w_single_res = A ^ B;
            OP_NOR:  w_single_res = ~(A | B);
            OP_LUI:  w_single_res = B << (WIDTH / 2);
            OP_SLTU: w_single_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_MUL, OP_MULHU: w_multi = 1'b1;
            OP_DIVU: begin
                if (B == '0) begin
                    w_single_res = '1;
                    w_single_dz  = 1'b1;
                end else begin
                    w_multi = 1'b1;
                end
            end
            OP_REMU: begin
                if (B == '0) begin
                    w_single_res = A;
                    w_single_dz  = 1'b1;
                end else begin
                    w_multi = 1'b1;
                end
            end
            default: w_single_res = '0;
        endcase
    end

    assign w_start_mul = (ALU_operation == OP_MUL) || (ALU_operation == OP_MULHU);
    assign w_is_mul    = (r_op == OP_MUL) || (r_op == OP_MULHU);

    // Multiply: {r_hi, r_lo} shifts right, r_lo starts as the multiplier.
    assign w_mul_sum = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_md}) : {1'b0, r_hi};
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_md});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_md;
    assign w_div_hi    = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
    assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_ge};

    assign w_next_hi = w_is_mul ? w_mul_hi : w_div_hi;
    assign w_next_lo = w_is_mul ? w_mul_lo : w_div_lo;

    always_comb begin
        w_run_res = w_next_hi;
        case (r_op)
            OP_MUL:   w_run_res = w_next_lo;
            OP_MULHU: w_run_res = w_next_hi;
            OP_DIVU:  w_run_res = w_next_lo;
            default:  w_run_res = w_next_hi;
        endcase
    end

    // Control FSM and datapath registers; start is only honoured outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_op       <= '0;
            r_md       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
            r_divzero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_op <= ALU_operation;
                        if (w_multi) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_count <= CW'(WIDTH - 1);
                            r_md    <= w_start_mul ? A : B;
                            r_lo    <= w_start_mul ? B : A;
                            r_hi    <= '0;
                        end else begin
                            r_state    <= DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_result   <= w_single_res;
                            r_zero     <= (w_single_res == '0);
                            r_overflow <= w_single_ovf;
                            r_divzero  <= w_single_dz;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                RUN: begin
                    r_hi <= w_next_hi;
                    r_lo <= w_next_lo;
                    if (r_count == '0) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_result   <= w_run_res;
                        r_zero     <= (w_run_res == '0);
                        r_overflow <= 1'b0;
                        r_divzero  <= 1'b0;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32: hand-computed vectors checked with
// immediate assertions, covering single-cycle ops, serial mul/div, div-by-zero and reset.
module tb_seq_alu;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_operation;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Overflow;
    logic             DivZero;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0]       b2bOps  [6] = '{4'd0, 4'd4, 4'd1, 4'd5, 4'd2, 4'd6};
    logic [WIDTH-1:0] b2bRes  [6] = '{32'd20, 32'd0, 32'd10, 32'd10, 32'd0, 32'h000A0000};
    logic             b2bZero [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    int lat;
    int busyCycles;
    int doneCount;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .A             (A),
        .B             (B),
        .ALU_operation (ALU_operation),
        .busy          (busy),
        .done          (done),
        .Result        (Result),
        .Zero          (Zero),
        .Overflow      (Overflow),
        .DivZero       (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [3:0] op);
        start         = s;
        A             = a;
        B             = b;
        ALU_operation = op;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue a single-cycle request and confirm done one edge later.
    task automatic runSingle(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
        applyStimulus(1'b1, a, b, op);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0BADF00D, 32'h0BADF00D, 4'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
    endtask

    // Issue a serial request and measure edges to done and busy cycles, with a bounded wait.
    task automatic runMulti(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input bit midPulse, output int latency, output int busyCount);
        applyStimulus(1'b1, a, b, op);
        @(posedge clk); #1;
        latency   = 1;
        busyCount = 0;
        while (done !== 1'b1 && latency < 100) begin
            if (busy === 1'b1) busyCount++;
            if (midPulse && latency == 10) applyStimulus(1'b1, 32'd1, 32'd2, 4'd0);
            else                           applyStimulus(1'b0, 32'hDEADBEEF, 32'h12345678, 4'd9);
            @(posedge clk); #1;
            latency++;
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 4'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", Result, 32'd0);
        checkOutput("rst_zero", 32'(Zero), 32'd1);
        checkOutput("rst_ovf", 32'(Overflow), 32'd0);
        checkOutput("rst_dz", 32'(DivZero), 32'd0);

        // Back-to-back single-cycle ops starting on the first edge after reset release.
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'd10, 32'd10, b2bOps[i]);
            @(posedge clk); #1;
            checkOutput($sformatf("b2b%0d_done", i), 32'(done), 32'd1);
            checkOutput($sformatf("b2b%0d_res", i), Result, b2bRes[i]);
            checkOutput($sformatf("b2b%0d_zero", i), 32'(Zero), 32'(b2bZero[i]));
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 4'd0);
        @(posedge clk); #1;
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_held", Result, 32'h000A0000);

        runSingle("addovf", 4'd0, 32'h7FFFFFFF, 32'd1);
        checkOutput("addovf_res", Result, 32'h80000000);
        checkOutput("addovf_ovf", 32'(Overflow), 32'd1);
        runSingle("subovf", 4'd4, 32'h80000000, 32'd1);
        checkOutput("subovf_res", Result, 32'h7FFFFFFF);
        checkOutput("subovf_ovf", 32'(Overflow), 32'd1);
        runSingle("sltu", 4'd7, 32'd3, 32'd5);
        checkOutput("sltu_res", Result, 32'd1);
        checkOutput("sltu_ovf", 32'(Overflow), 32'd0);
        runSingle("op12", 4'd12, 32'd5, 32'd5);
        checkOutput("op12_res", Result, 32'd0);
        checkOutput("op12_zero", 32'(Zero), 32'd1);

        // Serial multiply: latency and busy width are the timing-critical checks.
        runMulti(4'd8, 32'hFFFFFFFF, 32'd2, 1'b0, lat, busyCycles);
        checkOutput("mul_lat", 32'(lat), 32'd33);
        checkOutput("mul_busy", 32'(busyCycles), 32'd32);
        checkOutput("mul_res", Result, 32'hFFFFFFFE);
        runMulti(4'd9, 32'hFFFFFFFF, 32'd2, 1'b0, lat, busyCycles);
        checkOutput("mulhu_lat", 32'(lat), 32'd33);
        checkOutput("mulhu_busy", 32'(busyCycles), 32'd32);
        checkOutput("mulhu_res", Result, 32'h00000001);

        runMulti(4'd10, 32'd100, 32'd7, 1'b1, lat, busyCycles);
        checkOutput("divu_lat", 32'(lat), 32'd33);
        checkOutput("divu_res", Result, 32'd14);
        runMulti(4'd11, 32'd100, 32'd7, 1'b1, lat, busyCycles);
        checkOutput("remu_lat", 32'(lat), 32'd33);
        checkOutput("remu_res", Result, 32'd2);
        @(posedge clk); #1;
        checkOutput("remu_nodone", 32'(done), 32'd0);
        checkOutput("remu_nobusy", 32'(busy), 32'd0);

        runSingle("div0", 4'd10, 32'd55, 32'd0);
        checkOutput("div0_res", Result, 32'hFFFFFFFF);
        checkOutput("div0_dz", 32'(DivZero), 32'd1);
        runSingle("rem0", 4'd11, 32'd55, 32'd0);
        checkOutput("rem0_res", Result, 32'd55);
        checkOutput("rem0_dz", 32'(DivZero), 32'd1);
        runSingle("add2", 4'd0, 32'd1, 32'd1);
        checkOutput("add2_res", Result, 32'd2);
        checkOutput("add2_dz", 32'(DivZero), 32'd0);

        // Reset in the middle of a multiply must clear everything at once.
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'd2, 4'd8);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'd0);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_result", Result, 32'd0);
        checkOutput("arst_zero", 32'(Zero), 32'd1);
        checkOutput("arst_ovf", 32'(Overflow), 32'd0);
        checkOutput("arst_dz", 32'(DivZero), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) doneCount++;
        end
        checkOutput("arst_nodone", 32'(doneCount), 32'd0);
        runSingle("post", 4'd0, 32'd1, 32'd2);
        checkOutput("post_res", Result, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
